// File: rtl/seeg_cmd_ctrl.sv
// Host-side command sequencer driving the sEEG controller's record/zcheck strobes.
// Define SEEG_CMD_ZCHECK_TIMEOUT_EN to give up on a zcheck after ZCHECK_TIMEOUT cycles.
module seeg_cmd_ctrl #(
    parameter int          STOP_HOLD      = 64,
    parameter logic [31:0] ZCHECK_TIMEOUT = 32'd1000000,
    parameter int          TIMER_W        = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [TIMER_W-1:0] cmd_arg,
    output logic               rsp_valid,
    output logic [1:0]         rsp_code,
    output logic               record_start,
    output logic               record_stop,
    output logic               zcheck_start,
    input  logic               zcheck_done,
    output logic               busy,
    output logic               recording
);
    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_REC_START = 3'd1;
    localparam logic [2:0] OP_REC_STOP  = 3'd2;
    localparam logic [2:0] OP_ZCHECK    = 3'd3;
    localparam logic [2:0] OP_REC_TIMED = 3'd4;

    localparam logic [1:0] RSP_ACK     = 2'd0;
    localparam logic [1:0] RSP_REJECT  = 2'd1;
    localparam logic [1:0] RSP_DONE    = 2'd2;
    localparam logic [1:0] RSP_TIMEOUT = 2'd3;

    localparam int            SW        = $clog2(STOP_HOLD + 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_HOLD - 1);

    typedef enum logic [2:0] {S_IDLE, S_REC, S_REC_TIMED, S_STOPPING, S_ZCHECK} state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]      stop_cnt_q, stop_cnt_d;
    logic               zd_q;
    logic               pend_q, pend_d;
    logic [1:0]         pend_code_q, pend_code_d;
    logic               rsp_valid_d;
    logic [1:0]         rsp_code_d;
    logic               record_start_d, zcheck_start_d;
    logic               accept, done_rise, ev;
    logic [1:0]         ev_code, cmd_code;
`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
    logic [31:0]        zt_q, zt_d;
`endif

    assign accept    = cmd_valid && cmd_ready;
    assign done_rise = zcheck_done && !zd_q;

    // A completion that coincides with an accepted command is deferred one cycle via pend_q,
    // so ready must also stay low while it is pending.
    assign cmd_ready = (state_q != S_STOPPING) && !pend_q && !(rsp_valid && rsp_code[1]);
    assign record_stop = (state_q == S_STOPPING);
    assign busy        = (state_q != S_IDLE);
    assign recording   = (state_q == S_REC) || (state_q == S_REC_TIMED);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stop_cnt_d     = stop_cnt_q;
        pend_d         = 1'b0;
        pend_code_d    = pend_code_q;
        rsp_valid_d    = 1'b0;
        rsp_code_d     = RSP_ACK;
        record_start_d = 1'b0;
        zcheck_start_d = 1'b0;
        cmd_code       = RSP_REJECT;
        ev             = 1'b0;
        ev_code        = RSP_DONE;
`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
        zt_d           = zt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_NOP: cmd_code = RSP_ACK;
                        OP_REC_START: begin
                            cmd_code       = RSP_ACK;
                            state_d        = S_REC;
                            record_start_d = 1'b1;
                        end
                        OP_ZCHECK: begin
                            cmd_code       = RSP_ACK;
                            state_d        = S_ZCHECK;
                            zcheck_start_d = 1'b1;
`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
                            zt_d           = '0;
`endif
                        end
                        OP_REC_TIMED: begin
                            if (cmd_arg != '0) begin
                                cmd_code       = RSP_ACK;
                                cnt_d          = cmd_arg;
                                state_d        = S_REC_TIMED;
                                record_start_d = 1'b1;
                            end
                        end
                        default: cmd_code = RSP_REJECT;
                    endcase
                end
            end
            S_REC: begin
                if (accept) begin
                    if (cmd_op == OP_REC_STOP) begin
                        cmd_code   = RSP_ACK;
                        state_d    = S_STOPPING;
                        stop_cnt_d = '0;
                    end else if (cmd_op == OP_NOP) begin
                        cmd_code = RSP_ACK;
                    end
                end
            end
            S_REC_TIMED: begin
                if (cnt_q != '0)
                    cnt_d = cnt_q - TIMER_W'(1);
                if (cnt_q <= TIMER_W'(1)) begin
                    ev         = 1'b1;
                    ev_code    = RSP_DONE;
                    state_d    = S_STOPPING;
                    stop_cnt_d = '0;
                end
                // A stop on the final cycle wins: ACK only, the DONE is dropped.
                if (accept) begin
                    if (cmd_op == OP_REC_STOP) begin
                        cmd_code   = RSP_ACK;
                        ev         = 1'b0;
                        state_d    = S_STOPPING;
                        stop_cnt_d = '0;
                    end else if (cmd_op == OP_NOP) begin
                        cmd_code = RSP_ACK;
                    end
                end
            end
            S_STOPPING: begin
                if (stop_cnt_q == STOP_LAST)
                    state_d = S_IDLE;
                else
                    stop_cnt_d = stop_cnt_q + SW'(1);
            end
            S_ZCHECK: begin
                if (accept && cmd_op == OP_NOP)
                    cmd_code = RSP_ACK;
`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
                if (zt_q != ZCHECK_TIMEOUT)
                    zt_d = zt_q + 32'd1;
`endif
                if (done_rise) begin
                    ev      = 1'b1;
                    ev_code = RSP_DONE;
                    state_d = S_IDLE;
                end
`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
                else if (zt_q == ZCHECK_TIMEOUT - 32'd1) begin
                    ev      = 1'b1;
                    ev_code = RSP_TIMEOUT;
                    state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (pend_q) begin
            rsp_valid_d = 1'b1;
            rsp_code_d  = pend_code_q;
        end else if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_code_d  = cmd_code;
            if (ev) begin
                pend_d      = 1'b1;
                pend_code_d = ev_code;
            end
        end else if (ev) begin
            rsp_valid_d = 1'b1;
            rsp_code_d  = ev_code;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stop_cnt_q   <= '0;
            zd_q         <= 1'b0;
            pend_q       <= 1'b0;
            pend_code_q  <= RSP_ACK;
            rsp_valid    <= 1'b0;
            rsp_code     <= RSP_ACK;
            record_start <= 1'b0;
            zcheck_start <= 1'b0;
`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
            zt_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            zd_q         <= zcheck_done;
            pend_q       <= pend_d;
            pend_code_q  <= pend_code_d;
            rsp_valid    <= rsp_valid_d;
            rsp_code     <= rsp_code_d;
            record_start <= record_start_d;
            zcheck_start <= zcheck_start_d;
`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
            zt_q         <= zt_d;
`endif
        end
    end
endmodule

// File: tb/tb_seeg_cmd_ctrl.sv
// Directed testbench for seeg_cmd_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_seeg_cmd_ctrl;
`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
    localparam logic [31:0] ZTO   = 32'd20;
    localparam int          ZWAIT = 5;
`else
    localparam logic [31:0] ZTO   = 32'd1000000;
    localparam int          ZWAIT = 497;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic        record_start, record_stop, zcheck_start;
    logic        zcheck_done = 1'b0;
    logic        busy, recording;

    int total = 0;
    int bad = 0;

    seeg_cmd_ctrl #(.STOP_HOLD(64), .ZCHECK_TIMEOUT(ZTO), .TIMER_W(32)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .rsp_valid(rsp_valid), .rsp_code(rsp_code),
        .record_start(record_start), .record_stop(record_stop), .zcheck_start(zcheck_start),
        .zcheck_done(zcheck_done), .busy(busy), .recording(recording)
    );

    always #5 clk = ~clk;

    // Offer one command at the current falling edge; returns at the edge where its response is visible.
    task automatic send(input logic [2:0] op, input logic [31:0] arg);
        cmd_op = op;
        cmd_arg = arg;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic measure_stop(output int len, output int ready_seen, output int dones);
        len = 0;
        ready_seen = 0;
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            if (!record_stop) break;
            len++;
            if (cmd_ready) ready_seen++;
            if (rsp_valid && rsp_code == 2'd2) dones++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rstn = 1'b0;
        @(negedge clk);
        obs = {cmd_ready, rsp_valid, rsp_code, record_start, record_stop, zcheck_start, busy, recording};
        total++;
        if (obs !== 9'b1_0_00_0_0_0_0_0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b want 100000000", obs);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rec_start_stop();
        int len, rdy, dn;
        send(3'd1, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, record_start, recording, busy} !== 6'b1_00_111) begin
            bad++;
            $display("[TB] FAIL rec_start_ack: got %b want 100111", {rsp_valid, rsp_code, record_start, recording, busy});
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, record_start, recording} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL rec_start_pulse_end: got %b want 001", {rsp_valid, record_start, recording});
        end
        repeat (98) @(negedge clk);
        send(3'd2, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, record_stop, cmd_ready} !== 5'b1_00_10) begin
            bad++;
            $display("[TB] FAIL rec_stop_ack: got %b want 10010", {rsp_valid, rsp_code, record_stop, cmd_ready});
        end
        measure_stop(len, rdy, dn);
        total++;
        if (len != 64 || rdy != 0) begin
            bad++;
            $display("[TB] FAIL stop_hold: got len=%0d ready_cycles=%0d want len=64 ready_cycles=0", len, rdy);
        end
        total++;
        if ({busy, cmd_ready, recording} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL stop_to_idle: got %b want 010", {busy, cmd_ready, recording});
        end
    endtask

    task automatic test_rec_timed();
        int found, len, rdy, dn;
        send(3'd4, 32'd10);
        total++;
        if ({rsp_valid, rsp_code, record_start, recording} !== 5'b1_00_11) begin
            bad++;
            $display("[TB] FAIL timed_ack: got %b want 10011", {rsp_valid, rsp_code, record_start, recording});
        end
        found = -1;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid && rsp_code == 2'd2) begin
                found = i;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (found != 10 || cmd_ready !== 1'b0 || record_stop !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timed_done: got at=%0d ready=%b stop=%b want at=10 ready=0 stop=1", found, cmd_ready, record_stop);
        end
        measure_stop(len, rdy, dn);
        total++;
        if (len != 64 || dn != 1) begin
            bad++;
            $display("[TB] FAIL timed_stop_hold: got len=%0d dones=%0d want len=64 dones=1", len, dn);
        end
        send(3'd4, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, record_start, busy} !== 5'b1_01_00) begin
            bad++;
            $display("[TB] FAIL timed_zero_reject: got %b want 10100", {rsp_valid, rsp_code, record_start, busy});
        end
    endtask

    task automatic test_timed_boundary();
        int len, rdy, dn;
        // Stop accepted on the edge where the counter expires: ACK only.
        send(3'd4, 32'd5);
        repeat (4) @(negedge clk);
        send(3'd2, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, record_stop} !== 4'b1_00_1) begin
            bad++;
            $display("[TB] FAIL timed_stop_last_ack: got %b want 1001", {rsp_valid, rsp_code, record_stop});
        end
        @(negedge clk);
        measure_stop(len, rdy, dn);
        total++;
        if (len != 63 || dn != 0) begin
            bad++;
            $display("[TB] FAIL timed_stop_last_nodone: got len=%0d dones=%0d want len=63 dones=0", len, dn);
        end
        // NOP on the expiry edge: ACK first, DONE on the next cycle.
        send(3'd4, 32'd3);
        repeat (2) @(negedge clk);
        send(3'd0, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, cmd_ready} !== 4'b1_00_0) begin
            bad++;
            $display("[TB] FAIL timed_nop_last_ack: got %b want 1000", {rsp_valid, rsp_code, cmd_ready});
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_code} !== 3'b1_10) begin
            bad++;
            $display("[TB] FAIL timed_nop_last_done: got %b want 110", {rsp_valid, rsp_code});
        end
        measure_stop(len, rdy, dn);
    endtask

    task automatic test_zcheck();
        send(3'd3, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, zcheck_start, record_start, busy, recording} !== 7'b1_00_1010) begin
            bad++;
            $display("[TB] FAIL zcheck_ack: got %b want 1001010", {rsp_valid, rsp_code, zcheck_start, record_start, busy, recording});
        end
        send(3'd1, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, record_start, zcheck_start, busy} !== 6'b1_01_001) begin
            bad++;
            $display("[TB] FAIL zcheck_rec_reject: got %b want 101001", {rsp_valid, rsp_code, record_start, zcheck_start, busy});
        end
        repeat (ZWAIT) @(negedge clk);
        zcheck_done = 1'b1;
        @(negedge clk);
        zcheck_done = 1'b0;
        total++;
        if ({rsp_valid, rsp_code, cmd_ready, busy} !== 5'b1_10_00) begin
            bad++;
            $display("[TB] FAIL zcheck_done: got %b want 11000", {rsp_valid, rsp_code, cmd_ready, busy});
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL zcheck_after_done: got %b want 01", {rsp_valid, cmd_ready});
        end
        // Command accepted on the same edge as the done edge.
        send(3'd3, 32'd0);
        cmd_op = 3'd0;
        cmd_valid = 1'b1;
        zcheck_done = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        zcheck_done = 1'b0;
        total++;
        if ({rsp_valid, rsp_code, cmd_ready} !== 4'b1_00_0) begin
            bad++;
            $display("[TB] FAIL zcheck_same_ack: got %b want 1000", {rsp_valid, rsp_code, cmd_ready});
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_code, cmd_ready, busy} !== 5'b1_10_00) begin
            bad++;
            $display("[TB] FAIL zcheck_same_done: got %b want 11000", {rsp_valid, rsp_code, cmd_ready, busy});
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL zcheck_same_after: got %b want 01", {rsp_valid, cmd_ready});
        end
    endtask

`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
    task automatic test_zcheck_timeout();
        int found, extra;
        send(3'd3, 32'd0);
        found = -1;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid && rsp_code == 2'd3) begin
                found = i;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (found != 20 || busy !== 1'b0 || record_stop !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zcheck_timeout: got at=%0d busy=%b stop=%b want at=20 busy=0 stop=0", found, busy, record_stop);
        end
        repeat (2) @(negedge clk);
        zcheck_done = 1'b1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        zcheck_done = 1'b0;
        total++;
        if (extra != 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL late_done_ignored: got responses=%0d busy=%b want responses=0 busy=0", extra, busy);
        end
    endtask
`endif

    task automatic test_illegal();
        int len, rdy, dn;
        send(3'd6, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, busy} !== 4'b1_01_0) begin
            bad++;
            $display("[TB] FAIL illegal_idle: got %b want 1010", {rsp_valid, rsp_code, busy});
        end
        send(3'd2, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, record_stop} !== 4'b1_01_0) begin
            bad++;
            $display("[TB] FAIL stop_in_idle: got %b want 1010", {rsp_valid, rsp_code, record_stop});
        end
        send(3'd1, 32'd0);
        send(3'd5, 32'd0);
        total++;
        if ({rsp_valid, rsp_code, recording} !== 4'b1_01_1) begin
            bad++;
            $display("[TB] FAIL illegal_rec: got %b want 1011", {rsp_valid, rsp_code, recording});
        end
        send(3'd2, 32'd0);
        measure_stop(len, rdy, dn);
    endtask

    task automatic test_reset_mid_stop();
        send(3'd1, 32'd0);
        send(3'd2, 32'd0);
        repeat (10) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({record_stop, cmd_ready, busy, recording, rsp_valid} !== 5'b01000) begin
            bad++;
            $display("[TB] FAIL reset_mid_stop: got %b want 01000", {record_stop, cmd_ready, busy, recording, rsp_valid});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL reset_release: got %b want 001", {rsp_valid, busy, cmd_ready});
        end
    endtask

    initial begin
        test_reset();
        test_rec_start_stop();
        test_rec_timed();
        test_timed_boundary();
        test_zcheck();
`ifdef SEEG_CMD_ZCHECK_TIMEOUT_EN
        test_zcheck_timeout();
`endif
        test_illegal();
        test_reset_mid_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
